// File: rtl/counter_ctrl_pkg.sv
// Shared types and constants for the counter controller.
// Optional build macro: COUNTER_CTRL_STATS_EN (adds a completed-period counter).
package counter_ctrl_pkg;

    // Controller FSM states
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StRun  = 2'd2,
        StDone = 2'd3
    } state_e;

    // Width of the optional completed-period statistics counter
    localparam int unsigned STATS_W = 16;

endpackage : counter_ctrl_pkg

// File: rtl/counter_ctrl_if.sv
// Bundle of host-side control/status and counter-side signals for counter_ctrl.
// Optional build macro: COUNTER_CTRL_STATS_EN (adds periods_done).
interface counter_ctrl_if
    import counter_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 4
);
    // Host side
    logic             start;
    logic             abort;
    logic             mode_up;
    logic             auto_reload;
    logic             pause;
    logic [WIDTH-1:0] period;
    logic             busy;
    logic             done;
`ifdef COUNTER_CTRL_STATS_EN
    logic [STATS_W-1:0] periods_done;
`endif

    // Counter side
    logic             load_n;
    logic             ce;
    logic             up_down;
    logic [WIDTH-1:0] data_load;
    logic [WIDTH-1:0] count_out;
    logic             zero;

    // Host driving the controller
    modport master (
        output start, abort, mode_up, auto_reload, pause, period,
        input  busy, done
`ifdef COUNTER_CTRL_STATS_EN
        , input periods_done
`endif
    );

    // The controller itself
    modport slave (
        input  start, abort, mode_up, auto_reload, pause, period,
        output busy, done,
        output load_n, ce, up_down, data_load,
        input  count_out, zero
`ifdef COUNTER_CTRL_STATS_EN
        , output periods_done
`endif
    );

    // The up/down counter attached beside the controller
    modport cnt (
        input  load_n, ce, up_down, data_load,
        output count_out, zero
    );

endinterface : counter_ctrl_if

// File: rtl/counter_ctrl.sv
// Timing-period controller driving an external loadable up/down counter.
// Optional build macro: COUNTER_CTRL_STATS_EN (periods_done saturating counter).
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    counter_ctrl_if.slave bus
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             mode_q, mode_d;
    logic             term;

    // Terminal condition: reached period going up, reached zero going down
    always_comb begin
        term = mode_q ? (bus.count_out == period_q) : bus.zero;
    end

    // Next-state and latch update; abort wins over start and term
    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        mode_d   = mode_q;
        if (bus.abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        state_d  = StLoad;
                        period_d = bus.period;
                        mode_d   = bus.mode_up;
                    end
                end
                StLoad: state_d = StRun;
                StRun: begin
                    // Leaves on term even while paused
                    if (term) state_d = StDone;
                end
                StDone:  state_d = bus.auto_reload ? StLoad : StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // State and latch registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            period_q <= '0;
            mode_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            mode_q   <= mode_d;
        end
    end

    // Moore outputs from registered state; ce also gates on pause and term
    always_comb begin
        bus.busy      = (state_q != StIdle);
        bus.done      = (state_q == StDone);
        bus.load_n    = (state_q != StLoad);
        bus.ce        = (state_q == StRun) && !bus.pause && !term;
        bus.up_down   = (state_q == StRun) && mode_q;
        bus.data_load = '0;
        if (state_q == StLoad && !mode_q) begin
            bus.data_load = period_q;
        end
    end

`ifdef COUNTER_CTRL_STATS_EN
    logic [STATS_W-1:0] stats_q;

    // Saturating count of completed periods
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stats_q <= '0;
        end else if (state_q == StDone && stats_q != {STATS_W{1'b1}}) begin
            stats_q <= stats_q + 1'b1;
        end
    end

    assign bus.periods_done = stats_q;
`endif

endmodule : counter_ctrl

// File: tb/tb_counter_ctrl.sv
// Self-checking bench for counter_ctrl with a behavioural up/down counter attached.
module tb_counter_ctrl;
    import counter_ctrl_pkg::*;

    localparam int unsigned W = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    counter_ctrl_if #(.WIDTH(W)) bus ();

    counter_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Loadable up/down counter beside the controller
    logic [W-1:0] cnt_q;
    always_ff @(posedge clk) begin
        if (!rst_n)           cnt_q <= '0;
        else if (!bus.load_n) cnt_q <= bus.data_load;
        else if (bus.ce)      cnt_q <= bus.up_down ? cnt_q + 1'b1 : cnt_q - 1'b1;
    end
    assign bus.count_out = cnt_q;
    assign bus.zero      = (cnt_q == '0);

    int checks = 0;
    int errors = 0;
    int dones  = 0;

    typedef struct {
        logic [W-1:0] period;
        logic         mode_up;
        int           lat;
        int           ce_n;
        int           fin;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int idx);
        int edges, ce_n, maxc;
        bus.period  = vecs[idx].period;
        bus.mode_up = vecs[idx].mode_up;
        bus.start   = 1'b1;
        step();
        bus.start = 1'b0;
        chk($sformatf("v%0d load_n", idx), int'(bus.load_n), 0);
        chk($sformatf("v%0d data_load", idx), int'(bus.data_load),
            vecs[idx].mode_up ? 0 : int'(vecs[idx].period));
        edges = 0;
        ce_n  = 0;
        maxc  = 0;
        while (!bus.done && edges < 40) begin
            if (bus.ce) ce_n++;
            if (edges >= 1 && int'(cnt_q) > maxc) maxc = int'(cnt_q);
            step();
            edges++;
        end
        if (bus.done) dones++;
        chk($sformatf("v%0d latency", idx), edges, vecs[idx].lat);
        chk($sformatf("v%0d ce_cycles", idx), ce_n, vecs[idx].ce_n);
        chk($sformatf("v%0d final_count", idx), int'(cnt_q), vecs[idx].fin);
        chk($sformatf("v%0d max_count", idx), maxc, int'(vecs[idx].period));
        chk($sformatf("v%0d busy_at_done", idx), int'(bus.busy), 1);
        step();
        chk($sformatf("v%0d done_width", idx), int'(bus.done), 0);
        chk($sformatf("v%0d busy_after", idx), int'(bus.busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int edges, nd;
        vecs[0] = '{4'd3,  1'b0, 5,  3,  0};
        vecs[1] = '{4'd15, 1'b1, 17, 15, 15};
        vecs[2] = '{4'd0,  1'b0, 2,  0,  0};
        vecs[3] = '{4'd0,  1'b1, 2,  0,  0};
        vecs[4] = '{4'd1,  1'b1, 3,  1,  1};
        vecs[5] = '{4'd7,  1'b0, 9,  7,  0};

        rst_n           = 1'b0;
        bus.start       = 1'b0;
        bus.abort       = 1'b0;
        bus.mode_up     = 1'b0;
        bus.auto_reload = 1'b0;
        bus.pause       = 1'b0;
        bus.period      = '0;
        step();
        step();
        chk("rst busy", int'(bus.busy), 0);
        chk("rst done", int'(bus.done), 0);
        chk("rst load_n", int'(bus.load_n), 1);
        chk("rst ce", int'(bus.ce), 0);
        chk("rst up_down", int'(bus.up_down), 0);
        chk("rst data_load", int'(bus.data_load), 0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 6; i++) run_vec(i);

        // Pause for three cycles at count 2, down mode, period 4
        bus.period  = 4'd4;
        bus.mode_up = 1'b0;
        bus.start   = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("pause pre_count", int'(cnt_q), 2);
        bus.pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("pause hold%0d", i), int'(cnt_q), 2);
            chk($sformatf("pause ce%0d", i), int'(bus.ce), 0);
        end
        bus.pause = 1'b0;
        edges = 6;
        while (!bus.done && edges < 40) begin
            step();
            edges++;
        end
        if (bus.done) dones++;
        chk("pause latency", edges, 9);
        step();

        // Auto-reload, period 2, with ignored start/period/mode changes while busy
        bus.period      = 4'd2;
        bus.mode_up     = 1'b0;
        bus.auto_reload = 1'b1;
        bus.start       = 1'b1;
        step();
        bus.start = 1'b0;
        edges = 0;
        while (!bus.done && edges < 40) begin
            step();
            edges++;
        end
        if (bus.done) dones++;
        chk("reload first", edges, 4);
        for (int k = 0; k < 2; k++) begin
            edges = 0;
            do begin
                step();
                edges++;
                if (edges == 2) begin
                    bus.start   = 1'b1;
                    bus.period  = 4'd9;
                    bus.mode_up = 1'b1;
                end else begin
                    bus.start = 1'b0;
                end
            end while (!bus.done && edges < 40);
            if (bus.done) dones++;
            chk($sformatf("reload spacing%0d", k), edges, 5);
        end
        bus.auto_reload = 1'b0;
        step();
        chk("reload stop busy", int'(bus.busy), 0);

`ifdef COUNTER_CTRL_STATS_EN
        chk("stats count", int'(bus.periods_done), dones);
`endif

        // Abort at count 5 of an up-mode period of 9
        bus.period  = 4'd9;
        bus.mode_up = 1'b1;
        bus.start   = 1'b1;
        step();
        bus.start = 1'b0;
        edges = 0;
        do begin
            step();
            edges++;
        end while (!(edges >= 1 && cnt_q == 4'd5) && edges < 40);
        chk("abort reach5", edges, 6);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("abort busy", int'(bus.busy), 0);
        chk("abort done", int'(bus.done), 0);
        chk("abort load_n", int'(bus.load_n), 1);
        nd = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.done || bus.busy) nd++;
        end
        chk("abort no_done", nd, 0);

        // Synchronous reset mid-RUN overrides start and abort
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("midrun up_down", int'(bus.up_down), 1);
        rst_n     = 1'b0;
        bus.start = 1'b1;
        bus.abort = 1'b1;
        step();
        chk("midrst busy", int'(bus.busy), 0);
        chk("midrst done", int'(bus.done), 0);
        chk("midrst load_n", int'(bus.load_n), 1);
        chk("midrst ce", int'(bus.ce), 0);
        chk("midrst up_down", int'(bus.up_down), 0);
        chk("midrst data_load", int'(bus.data_load), 0);
        bus.abort = 1'b0;
        step();
        chk("midrst start_ignored", int'(bus.busy), 0);
`ifdef COUNTER_CTRL_STATS_EN
        chk("midrst stats", int'(bus.periods_done), 0);
`endif
        rst_n     = 1'b1;
        bus.start = 1'b0;
        step();
        chk("post_rst busy", int'(bus.busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_counter_ctrl
